// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 double constants, divider state encoding and field helpers
package fp_pkg;

    localparam int FP_W   = 64;
    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int BIAS   = 1023;
    localparam int ITER   = 56;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } fpdiv_state_t;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[63];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[62:52];
    endfunction

    function automatic logic [FRAC_W-1:0] fp_frac(input logic [FP_W-1:0] x);
        return x[51:0];
    endfunction

    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return x[62:0] == 63'h0;
    endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round: combinational round-to-nearest-even of a normalized 53-bit significand
module fp_round (
    input  logic [52:0] i_sig,
    input  logic        i_l,
    input  logic        i_g,
    input  logic        i_r,
    input  logic        i_s,
    output logic [51:0] o_frac,
    output logic        o_carry
);

    logic        w_up;
    logic [53:0] w_sum;

    assign w_up    = i_g & (i_r | i_s | i_l);
    assign w_sum   = {1'b0, i_sig} + {53'h0, w_up};
    assign o_carry = w_sum[53];
    // With the hidden bit set, bit 52 survives unless the increment carried out,
    // in which case the significand became exactly 2.0 and the fraction is zero.
    assign o_frac  = w_sum[52] ? w_sum[51:0] : 52'h0;

endmodule

// File: rtl/fp_div.sv
// fp_div: sequential double-precision divider, restoring radix-2, RNE rounding.
// Optional FPDIV_ZERO_EN: zero divisor gives signed infinity, zero dividend gives signed zero.
module fp_div
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] N1,
    input  logic [63:0] N2,
    output logic        busy,
    output logic        done,
    output logic [63:0] out
);

    localparam logic [5:0] LAST = 6'(ITER - 1);

    fpdiv_state_t r_state;
    logic         r_s;
    logic [10:0]  r_exp;
    logic [53:0]  r_rem;
    logic [52:0]  r_d;
    logic [55:0]  r_q;
    logic [5:0]   r_cnt;
    logic         r_done;
    logic [63:0]  r_out;

    logic         w_ge;
    logic [52:0]  w_diff;
    logic [53:0]  w_rem_nx;
    logic         w_hi;
    logic [52:0]  w_sig;
    logic         w_l;
    logic         w_g;
    logic         w_r;
    logic         w_sx;
    logic [51:0]  w_frac;
    logic         w_carry;
    logic [10:0]  w_exp_o;
    logic [63:0]  w_res;

    // A partial remainder below 2d means the difference fits in 53 bits and the
    // shifted remainder never needs bit 53 of the pre-shift value.
    assign w_ge     = r_rem >= {1'b0, r_d};
    assign w_diff   = r_rem[52:0] - r_d;
    assign w_rem_nx = w_ge ? {w_diff, 1'b0} : {r_rem[52:0], 1'b0};

    // Quotient lies in (0.5, 2): q[55] selects whether a left normalize is needed.
    assign w_hi  = r_q[55];
    assign w_sig = w_hi ? r_q[55:3] : r_q[54:2];
    assign w_l   = w_hi ? r_q[3] : r_q[2];
    assign w_g   = w_hi ? r_q[2] : r_q[1];
    assign w_r   = w_hi ? r_q[1] : r_q[0];
    assign w_sx  = (w_hi & r_q[0]) | (|r_rem);

    fp_round u_round (
        .i_sig   (w_sig),
        .i_l     (w_l),
        .i_g     (w_g),
        .i_r     (w_r),
        .i_s     (w_sx),
        .o_frac  (w_frac),
        .o_carry (w_carry)
    );

    assign w_exp_o = r_exp - {10'h0, ~w_hi} + {10'h0, w_carry};

`ifdef FPDIV_ZERO_EN
    logic r_z1;
    logic r_z2;

    // Zero-operand flags captured with the operands, which need not be held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z1 <= 1'b0;
            r_z2 <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_z1 <= fp_is_zero(N1);
            r_z2 <= fp_is_zero(N2);
        end
    end

    assign w_res = r_z2 ? {r_s, 11'h7FF, 52'h0} :
                   r_z1 ? {r_s, 63'h0} :
                          {r_s, w_exp_o, w_frac};
`else
    assign w_res = {r_s, w_exp_o, w_frac};
`endif

    // Control FSM and datapath: accept in IDLE, one quotient bit per DIV cycle, round in NORM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= 1'b0;
            r_exp   <= 11'h0;
            r_rem   <= 54'h0;
            r_d     <= 53'h0;
            r_q     <= 56'h0;
            r_cnt   <= 6'h0;
            r_done  <= 1'b0;
            r_out   <= 64'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_s     <= fp_sign(N1) ^ fp_sign(N2);
                    // Only the low 11 bits of the exponent survive the silent wrap.
                    r_exp   <= fp_exp(N1) - fp_exp(N2) + 11'(BIAS);
                    r_rem   <= {2'b01, fp_frac(N1)};
                    r_d     <= {1'b1, fp_frac(N2)};
                    r_q     <= 56'h0;
                    r_cnt   <= 6'h0;
                    r_state <= DIV;
                end
                DIV: begin
                    r_q     <= {r_q[54:0], w_ge};
                    r_rem   <= w_rem_nx;
                    r_cnt   <= r_cnt + 6'd1;
                    r_state <= (r_cnt == LAST) ? NORM : DIV;
                end
                NORM: begin
                    r_out   <= w_res;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_state != IDLE;
    assign done = r_done;
    assign out  = r_out;

endmodule
